// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: bus widths, enable levels,
// FSM encodings and the buffered fetch entry.
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD    = '0;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;
  localparam logic              RST_ENABLE   = 1'b1;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf.sv
// Circular FIFO of fetched {pc, inst} entries with a branch-specific
// keep_second operation that retains only the delay-slot entry.
module inst_fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  input  logic         keep_second,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output fetch_entry_t second
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  assign tail_ptr = head_ptr + count[PW-1:0];
  assign head     = mem[head_ptr];
  assign second   = mem[head_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      head_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (keep_second) begin
      head_ptr <= head_ptr + PW'(1);
      count    <= CW'(1);
    end else begin
      if (pop) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear && !keep_second) mem[tail_ptr] <= push_entry;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: drives the ROM, buffers fetched words for decode
// and applies branch (with delay slot) and exception redirects.
//   state  | meaning
//   S_BOOT | first cycle after reset, ROM disabled
//   S_RUN  | fetching whenever the buffer has room
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  output logic                   rom_ce_o,
  input  logic [INST_W-1:0]      rom_data_i,
  input  logic                   id_ready_i,
  output logic                   if_valid_o,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if_state_t              state_q, state_n;
  logic [INST_ADDR_W-1:0] pc_q, pc_n;
  logic [CW-1:0]          count;
  fetch_entry_t           head_entry, second_entry;
  logic                   fetch, pop, valid;
  logic                   buf_push, buf_clear, buf_keep;

  assign valid      = (count != '0);
  assign fetch      = (state_q == S_RUN) && (count < DEPTH_C);
  assign pop        = valid && id_ready_i;
  assign rom_ce_o   = fetch ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = pc_q;
  assign if_valid_o = valid;
  assign if_pc_o    = valid ? head_entry.pc   : ZERO_WORD;
  assign if_inst_o  = valid ? head_entry.inst : ZERO_WORD;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    buf_push  = 1'b0;
    buf_clear = 1'b0;
    buf_keep  = 1'b0;
    if (state_q == S_BOOT) state_n = S_RUN;
    if (flush_i) begin
      buf_clear = 1'b1;
      pc_n      = new_pc_i;
    end else if (branch_flag_i && pop) begin
      // Delay slot is either already buffered behind the head or being fetched now.
      pc_n = branch_target_address_i;
      if (count >= CW'(2)) buf_keep = 1'b1;
      else                 buf_push = fetch;
    end else if (fetch) begin
      buf_push = 1'b1;
      pc_n     = pc_q + 32'd4;
    end
  end

  inst_fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push        (buf_push),
    .push_entry  ('{pc: pc_q, inst: rom_data_i}),
    .pop         (pop),
    .clear       (buf_clear),
    .keep_second (buf_keep),
    .count       (count),
    .head        (head_entry),
    .second      (second_entry)
  );

  a_branch_in_pop : assert property (@(posedge clk) disable iff (rst)
    branch_flag_i |-> pop);

  a_keep_delay_slot : assert property (@(posedge clk) disable iff (rst)
    (buf_keep && !flush_i) |=> (head_entry == $past(second_entry)));

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle table for reset/streaming/backpressure, hand-written
// redirect sequences, and a scoreboard of instructions accepted by decode.
module tb_inst_fetch;

  localparam logic [31:0] INST_KEY = 32'h5A00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        flush_i;
  logic [31:0] new_pc_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign rom_data_i = rom_addr_o ^ INST_KEY;

  inst_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .rom_addr_o              (rom_addr_o),
    .rom_ce_o                (rom_ce_o),
    .rom_data_i              (rom_data_i),
    .id_ready_i              (id_ready_i),
    .if_valid_o              (if_valid_o),
    .if_pc_o                 (if_pc_o),
    .if_inst_o               (if_inst_o),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted instruction must match the next expected pc in order.
  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid_o === 1'b1 && id_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_pop: got pc %h expected none", if_pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        cmp("sb_pc", if_pc_o, e);
        cmp("sb_inst", if_inst_o, e ^ INST_KEY);
      end
    end
  end

  task automatic step(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                      input logic fl, input logic [31:0] npc,
                      input logic ece, input logic [31:0] eaddr, input logic ev,
                      input logic [31:0] epc, input string tag);
    rst = r; id_ready_i = rdy; branch_flag_i = br; branch_target_address_i = tgt;
    flush_i = fl; new_pc_i = npc;
    @(negedge clk);
    cmp({tag, "_ce"},    {31'd0, rom_ce_o},   {31'd0, ece});
    cmp({tag, "_addr"},  rom_addr_o,          eaddr);
    cmp({tag, "_valid"}, {31'd0, if_valid_o}, {31'd0, ev});
    cmp({tag, "_pc"},    if_pc_o,             epc);
    cmp({tag, "_inst"},  if_inst_o,           ev ? (epc ^ INST_KEY) : 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_ready_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
    branch_target_address_i = '0; new_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;

    //           rst rdy ce  addr   valid pc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0c, 1'b1, 32'h08};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0c};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0c};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0c};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0c};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0c};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0c};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h1c, 1'b1, 32'h18};

    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
    exp_q.push_back(32'h0c); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    for (int i = 0; i < 15; i++)
      step(vecs[i].rst, vecs[i].rdy, 1'b0, 32'h0, 1'b0, 32'h0,
           vecs[i].ce, vecs[i].addr, vecs[i].valid, vecs[i].pc, $sformatf("v%0d", i));

    // Branch with the delay slot already buffered (head 0x18, 0x1c behind).
    exp_q.push_back(32'h18); exp_q.push_back(32'h1c); exp_q.push_back(32'h100);
    step(0, 1, 1, 32'h100, 0, 0, 0, 32'h20,  1, 32'h18, "br2_pop");
    step(0, 1, 0, 32'h0,   0, 0, 1, 32'h100, 1, 32'h1c, "br2_slot");

    // Branch with the delay slot fetched in the branch cycle.
    exp_q.push_back(32'h104); exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    step(0, 1, 1, 32'h200, 0, 0, 1, 32'h104, 1, 32'h100, "br1_pop");
    step(0, 1, 0, 32'h0,   0, 0, 1, 32'h200, 1, 32'h104, "br1_slot");
    step(0, 1, 0, 32'h0,   0, 0, 1, 32'h204, 1, 32'h200, "br1_tgt");

    // Flush wins over a simultaneous branch.
    exp_q.push_back(32'h180);
    step(0, 1, 1, 32'h300, 1, 32'h180, 1, 32'h208, 1, 32'h204, "fl_cyc");
    step(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h180, 0, 32'h0,   "fl_empty");
    step(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h184, 1, 32'h180, "fl_head");

    // Reset while the buffer is full.
    exp_q.push_back(32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h188, 1, 32'h184, "rs_fill");
    step(1, 0, 0, 0, 0, 0, 0, 32'h18c, 1, 32'h184, "rs_full");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,   "rs_boot");
    step(0, 0, 0, 0, 0, 0, 1, 32'h0,   0, 32'h0,   "rs_fetch");
    step(0, 1, 0, 0, 0, 0, 1, 32'h4,   1, 32'h0,   "rs_head");
    step(0, 0, 0, 0, 0, 0, 1, 32'h8,   1, 32'h4,   "rs_next");

    cmp("sb_leftover", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the in-order MIPS core. It drives the instruction ROM's address and chip-enable and captures the ROM's same-cycle read data. Fetched words go into a small decoupling buffer that hands instructions to decode over a valid/ready handshake. It also applies branch redirects, keeping the MIPS delay slot, and exception flushes.

## Interface
- `RESET_PC`, default 32'h0000_0000, is the first fetch address after reset.
- `DEPTH`, default 2, is the number of buffer entries. It must be a power of two and at least 2.
- `clk` in 1: single clock. Everything is rising-edge.
- `rst` in 1: one clock; reset is synchronous and active-high (`RstEnable` = 1'b1).
- `rom_addr_o` out 32 (`InstAddrBus`): fetch byte address. It equals the internal PC.
- `rom_ce_o` out 1: ROM chip enable. It is `ChipEnable` only when a fetch is issued.
- `rom_data_i` in 32 (`InstBus`): ROM read data, valid in the same cycle as address and enable.
- `id_ready_i` in 1: decode accepts the head entry this cycle.
- `if_valid_o` out 1: the head entry is valid.
- `if_pc_o` out 32: PC of the head entry. It is `ZeroWord` when `if_valid_o`=0.
- `if_inst_o` out 32: instruction of the head entry. It is `ZeroWord` when `if_valid_o`=0.
- `branch_flag_i` in 1: taken branch or jump. It is asserted only in a pop cycle (`if_valid_o & id_ready_i`) of the branch instruction.
- `branch_target_address_i` in 32: branch target.
- `flush_i` in 1: exception flush.
- `new_pc_i` in 32: exception handler address.

## Operation
- The FSM has two states.
  - S_BOOT is the reset state. `rom_ce_o`=0 and no fetch happens. It always moves to S_RUN on the next cycle.
  - S_RUN is the operating state. It leaves only on `rst`.
- Fetch condition: `fetch = (state==S_RUN) & (count < DEPTH)`, where `count` is the registered occupancy. `rom_ce_o = fetch`.
- There is no combinational path from `id_ready_i` to the ROM.
- Pop condition: `pop = if_valid_o & id_ready_i`.
- Sequential fetch (no redirect): push `{pc, rom_data_i}` and set `pc <= pc + 4`. The add wraps modulo 2^32.
- Simultaneous push and pop leaves `count` unchanged.
- Redirect priority is `rst` > `flush_i` > `branch_flag_i` > sequential.
- `flush_i`:
  - Empty the buffer.
  - Set `pc <= new_pc_i`.
  - Discard any data fetched this cycle.
  - Ignore `branch_flag_i`.
- `branch_flag_i`: the entry behind the popped head is the delay slot.
  - If `count >= 2`: keep exactly that entry as the new head, discard all others, set `pc <= branch_target_address_i`, and push nothing.
  - If `count == 1`: fetch is active this cycle. Push the fetched word (the delay slot at `pc`) and set `pc <= branch_target_address_i`.
- `branch_flag_i` outside a pop cycle is a protocol violation. Assert on it in simulation. In RTL, ignore it.
- `rom_addr_o` bits [1:0] are always 0 as long as the targets are word-aligned. Misalignment is decode's responsibility, so the bits are passed through unchanged.

## Timing
- Reset values:
  - state = S_BOOT, `pc` = `RESET_PC`, `count` = 0.
  - `rom_ce_o` = 0, `rom_addr_o` = `RESET_PC`.
  - `if_valid_o` = 0, `if_pc_o` = 0, `if_inst_o` = 0.
- After `rst` deasserts:
  - Cycle 0 is S_BOOT with `rom_ce_o`=0.
  - Cycle 1 issues the first fetch at `RESET_PC`.
  - Cycle 2 shows `if_valid_o`=1 with `if_pc_o`=`RESET_PC`.
- Fetch-to-decode latency is 1 cycle. With `id_ready_i` held at 1, throughput is 1 instruction per cycle at steady `count`=1.
- A redirect in cycle N puts the target address on `rom_addr_o` in cycle N+1. The target instruction reaches `if_valid_o` in N+2.
- Reset mid-operation clears the buffer and PC in the same edge. Any in-flight entries are lost.

## Structure
- `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, `ChipDisable` and `RstEnable` come from the shared defines file.
- The FSM state encodings are also added to the shared defines file.
- Sub-module `inst_fetch_buf` is a `DEPTH`-entry circular FIFO of `{pc, inst}`. It provides:
  - push, pop and clear;
  - `keep_second` for the branch case;
  - count, head and second-entry outputs.
- The top level holds the FSM, the PC register and the redirect logic.

## Test plan
- Reset and streaming:
  - Stimulus: the ROM model returns `inst = addr`; `id_ready_i`=1.
  - Response: `rom_ce_o` is 0 in the first cycle after reset. `if_pc_o`/`if_inst_o` then run 0,0 / 4,4 / 8,8 with no bubbles.
- Backpressure:
  - Stimulus: hold `id_ready_i`=0 for 5 cycles from the first valid cycle.
  - Response: `count` saturates at 2 and `rom_ce_o`=0 while full. The head holds pc 0. After release, decode receives 0, 4, 8 with no gap and no duplicate.
- Branch with buffered delay slot:
  - Stimulus: `count`=2 (pc 0x10 head, 0x14 behind) and `id_ready_i`=0 before the branch cycle; pop 0x10 with `branch_flag_i`=1 and target 0x100.
  - Response: the next heads are 0x14, then 0x100.
- Branch with unbuffered delay slot:
  - Stimulus: `count`=1 (head 0x10), `pc`=0x14, `id_ready_i`=1; pop 0x10 with the branch to 0x200.
  - Response: 0x14 is pushed, and the sequence is 0x10, 0x14, 0x200, 0x204.
- Flush beats branch:
  - Stimulus: `flush_i`=1 with `new_pc_i`=0x180 and `branch_flag_i`=1 in the same cycle.
  - Response: the buffer is empty and the next valid pc is 0x180.
- Reset mid-stream:
  - Stimulus: assert `rst` for 1 cycle while `count`=2.
  - Response: all outputs return to their reset values, and fetch restarts at `RESET_PC` two cycles later.
